vga_frame_feeder: RTL and testbench

- Upstream stage of the VGA driver write port.
- Accepts one 256x256 8-bit grayscale image from the image coprocessor over a valid/ready stream.
- Converts each pixel to RGB444 and drives the driver's start / we / img_idx / wdata inputs.
- Issues the start pulse, paces the 65536 writes, reports frame completion, and supports abort.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_gray2rgb.sv | 37 +++
 rtl/vga_frame_feeder.sv | 144 ++++++++++++++
 tb/tb_vga_frame_feeder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame feeder: FSM states, frame geometry,
// output colour width and the 2x2 ordered-dither threshold table.
package vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int IMG_DIM      = 256;
    localparam int FRAME_PIXELS = IMG_DIM * IMG_DIM;
    localparam int RGB_W        = 12;

    // Dither thresholds indexed by {y[0], x[0]}: (0,0)=0, (1,0)=8, (0,1)=12, (1,1)=4
    localparam logic [3:0][7:0] DITHER_T = {8'd4, 8'd12, 8'd8, 8'd0};

endpackage

// File: rtl/vga_gray2rgb.sv
// Stage-2 colour conversion: grayscale pixel to RGB444 with equal channels.
// Build option VGA_FEED_DITHER_EN adds a saturating 2x2 ordered dither ahead
// of the truncation to 4 bits; without it the position inputs are ignored.
module vga_gray2rgb import vga_pkg::*; #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] pix,
    input  logic             x0,
    input  logic             y0,
    output logic [RGB_W-1:0] rgb
);

    logic [3:0] g4;
    logic       unused_low;

`ifdef VGA_FEED_DITHER_EN
    // Add a threshold and clamp at full scale instead of wrapping
    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a,
                                                 input logic [7:0]       t);
        logic [PIX_W:0] s;
        s = {1'b0, a} + (PIX_W+1)'(t);
        return s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
    endfunction

    logic [PIX_W-1:0] v;

    assign v          = sat_add(pix, DITHER_T[{y0, x0}]);
    assign g4         = v[PIX_W-1 -: 4];
    assign unused_low = ^v[PIX_W-5:0];
`else
    assign g4         = pix[PIX_W-1 -: 4];
    assign unused_low = ^{x0, y0, pix[PIX_W-5:0]};
`endif

    assign rgb = {g4, g4, g4};

endmodule

// File: rtl/vga_frame_feeder.sv
// VGA frame feeder: accepts one IMG_DIM x IMG_DIM grayscale frame over a
// valid/ready stream and drives the VGA driver write port (start, we,
// img_idx, wdata) through a 2-stage pipeline. Build option
// VGA_FEED_DITHER_EN enables ordered dither in the colour conversion.
module vga_frame_feeder #(
    parameter int PIX_W   = 8,
    parameter int IMG_DIM = vga_pkg::IMG_DIM,
    parameter int CNT_W   = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_req,
    input  logic                      frame_img_idx,
    input  logic                      frame_abort,
    output logic                      frame_busy,
    output logic                      frame_done,
    input  logic                      pix_valid,
    input  logic [PIX_W-1:0]          pix_data,
    output logic                      pix_ready,
    output logic                      vga_start,
    output logic                      vga_img_idx,
    output logic                      vga_we,
    output logic [vga_pkg::RGB_W-1:0] vga_wdata
);

    import vga_pkg::*;

    localparam int               TOTAL   = IMG_DIM * IMG_DIM;
    localparam int               POS_W   = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [POS_W-1:0] P_LAST  = POS_W'(IMG_DIM - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt, out_cnt;
    logic [POS_W-1:0]   x_pos, y_pos;
    logic               img_idx_q;
    logic               hs, last_in, last_out;
    logic               vld_p1, x0_p1, y0_p1;
    logic [PIX_W-1:0]   pix_p1;
    logic [RGB_W-1:0]   rgb_p1;
    logic               vld_p2;
    logic [RGB_W-1:0]   wdata_p2;

    assign pix_ready = (state_q == ST_STREAM) && (in_cnt < TOTAL_C);
    assign hs        = pix_valid && pix_ready;
    assign last_in   = hs && (in_cnt == TOTAL_C - 1'b1);
    // The final write retires this cycle, so DONE follows immediately after it
    assign last_out  = vld_p2 && (out_cnt == TOTAL_C - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and frame-level control outputs; abort overrides everything
    always_comb begin
        state_d    = state_q;
        frame_busy = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
        vga_start  = (state_q == ST_START);
        if (frame_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (frame_req) state_d = ST_START;
                ST_START:  state_d = ST_STREAM;
                ST_STREAM: if (last_in) state_d = ST_DRAIN;
                ST_DRAIN:  if (last_out) state_d = ST_DONE;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Image slot is captured only when a request is actually accepted
    always_ff @(posedge clk) begin
        if (!rst_n)
            img_idx_q <= 1'b0;
        else if ((state_q == ST_IDLE) && frame_req && !frame_abort)
            img_idx_q <= frame_img_idx;
    end

    // Pixel counters and raster position; cleared at frame start and on abort
    always_ff @(posedge clk) begin
        if (!rst_n || frame_abort || (state_q == ST_START)) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            x_pos   <= '0;
            y_pos   <= '0;
        end else begin
            if (hs) begin
                in_cnt <= in_cnt + 1'b1;
                if (x_pos == P_LAST) begin
                    x_pos <= '0;
                    y_pos <= (y_pos == P_LAST) ? '0 : y_pos + 1'b1;
                end else begin
                    x_pos <= x_pos + 1'b1;
                end
            end
            if (vld_p2) out_cnt <= out_cnt + 1'b1;
        end
    end

    // ---- stage 1: capture accepted pixel and its position parity ----
    // Pipeline valids; abort flushes anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n || frame_abort) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= hs;
            vld_p2 <= vld_p1;
        end
    end

    // Stage-1 data register, loaded only on a handshake
    always_ff @(posedge clk) begin
        if (hs) begin
            pix_p1 <= pix_data;
            x0_p1  <= x_pos[0];
            y0_p1  <= y_pos[0];
        end
    end

    // ---- stage 2: colour conversion and output register ----
    vga_gray2rgb #(.PIX_W(PIX_W)) u_conv (
        .pix (pix_p1),
        .x0  (x0_p1),
        .y0  (y0_p1),
        .rgb (rgb_p1)
    );

    // Output pixel register; cleared by reset so the port reads 0 afterwards
    always_ff @(posedge clk) begin
        if (!rst_n)      wdata_p2 <= '0;
        else if (vld_p1) wdata_p2 <= rgb_p1;
    end

    assign vga_we      = vld_p2;
    assign vga_wdata   = wdata_p2;
    assign vga_img_idx = img_idx_q;

endmodule

// File: tb/tb_vga_frame_feeder.sv
// Bench for vga_frame_feeder on a 64x64 frame. Pixels are random; expected
// output colours come from a per-pixel model of the conversion rule (with
// the dither rule when VGA_FEED_DITHER_EN is defined).
module tb_vga_frame_feeder;

    localparam int DIM   = 64;
    localparam int TOTAL = DIM * DIM;
    localparam int CW    = 13;

    logic        clk = 1'b0;
    logic        rst_n, frame_req, frame_img_idx, frame_abort, pix_valid;
    logic [7:0]  pix_data;
    logic        frame_busy, frame_done, pix_ready, vga_start, vga_img_idx, vga_we;
    logic [11:0] vga_wdata;

    always #5 clk = ~clk;

    vga_frame_feeder #(.PIX_W(8), .IMG_DIM(DIM), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_req     (frame_req),
        .frame_img_idx (frame_img_idx),
        .frame_abort   (frame_abort),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .vga_start     (vga_start),
        .vga_img_idx   (vga_img_idx),
        .vga_we        (vga_we),
        .vga_wdata     (vga_wdata)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  img [TOTAL];
    logic [11:0] got [TOTAL];

    int r_writes, r_order_err, r_lat_err, r_starts, r_both, r_idx_err, r_dones;
    int r_done_cyc, r_first_we, r_last_we, r_last_hs, r_ready_after, r_req_cyc;
    int r_start_cyc, r_we_after_abort, r_busy_after_abort, r_busy_after_done;
    int r_timeout, r_sent, r_left;

    // Expected RGB444 word for pixel value p at raster index k
    function automatic logic [11:0] ref_rgb(input logic [7:0] p, input int k);
        int v;
        logic [3:0] g;
        v = int'(p);
`ifdef VGA_FEED_DITHER_EN
        case (((k / DIM) % 2) * 2 + (k % DIM) % 2)
            0:       v = v + 0;
            1:       v = v + 8;
            2:       v = v + 12;
            default: v = v + 4;
        endcase
        if (v > 255) v = 255;
`else
        if (k >= TOTAL) v = 0;
`endif
        g = 4'(v / 16);
        return {g, g, g};
    endfunction

    // Drive one frame from the current image and record what the DUT does
    task automatic run_frame(input logic idx, input int vpct, input int abort_at,
                             input bit req_with_abort, input bit req_mid);
        logic [11:0] exp_q[$];
        int          expc_q[$];
        logic [11:0] e;
        int          c, abort_cyc, bound;
        bit          aborted, mid_done;
        r_writes = 0; r_order_err = 0; r_lat_err = 0; r_starts = 0; r_both = 0;
        r_idx_err = 0; r_dones = 0; r_done_cyc = -1; r_first_we = -1; r_last_we = -1;
        r_last_hs = -1; r_ready_after = 0; r_start_cyc = -1; r_we_after_abort = 0;
        r_busy_after_abort = 0; r_busy_after_done = 0; r_timeout = 0; r_sent = 0;
        aborted = 0; mid_done = 0; abort_cyc = 0;
        @(negedge clk);
        frame_req = 1'b1; frame_img_idx = idx; frame_abort = 1'b0; pix_valid = 1'b0;
        r_req_cyc = cyc;
        bound = cyc + TOTAL * ((vpct < 100) ? 4 : 1) + 200;
        forever begin
            @(negedge clk);
            frame_req = 1'b0; frame_abort = 1'b0; frame_img_idx = 1'($urandom_range(0, 1));
            if (vga_start) begin r_starts++; r_start_cyc = cyc; end
            if (vga_we) begin
                if (vga_start) r_both++;
                if (aborted) r_we_after_abort++;
                else begin
                    if (r_writes == 0) r_first_we = cyc;
                    r_last_we = cyc;
                    if (r_writes < TOTAL) got[r_writes] = vga_wdata;
                    if (exp_q.size() == 0) r_order_err++;
                    else begin
                        e = exp_q.pop_front();
                        c = expc_q.pop_front();
                        if (e !== vga_wdata) r_order_err++;
                        if (c != cyc) r_lat_err++;
                    end
                    r_writes++;
                end
            end
            if (frame_busy && !aborted && vga_img_idx !== idx) r_idx_err++;
            if (frame_done) begin r_dones++; r_done_cyc = cyc; end
            if (aborted && frame_busy) r_busy_after_abort++;
            if (r_dones > 0 && cyc == r_done_cyc + 1 && frame_busy) r_busy_after_done++;
            if (pix_ready && r_sent == TOTAL) r_ready_after++;
            if (r_dones > 0 && cyc >= r_done_cyc + 3) break;
            if (aborted && cyc >= abort_cyc + 20) break;
            if (cyc > bound) begin r_timeout = 1; break; end
            if (!aborted && abort_at >= 0 && r_writes == abort_at) begin
                frame_abort = 1'b1; frame_req = req_with_abort; aborted = 1; abort_cyc = cyc;
            end
            if (req_mid && !mid_done && r_writes == 500) begin
                frame_req = 1'b1; frame_img_idx = ~idx; mid_done = 1;
            end
            pix_valid = ($urandom_range(0, 99) < vpct);
            pix_data  = (r_sent < TOTAL) ? img[r_sent] : 8'($urandom);
            if (pix_valid && pix_ready && !aborted) begin
                exp_q.push_back(ref_rgb(img[r_sent], r_sent));
                expc_q.push_back(cyc + 2);
                r_sent++;
                r_last_hs = cyc;
            end
        end
        r_left = exp_q.size();
        pix_valid = 1'b0; frame_req = 1'b0; frame_abort = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < TOTAL; i++) img[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        int n, t;
        rst_n = 1'b0; frame_req = 1'b0; frame_img_idx = 1'b0; frame_abort = 1'b0;
        pix_valid = 1'b0; pix_data = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({frame_busy, frame_done, pix_ready, vga_start, vga_img_idx, vga_we, vga_wdata} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {frame_busy, frame_done, pix_ready, vga_start, vga_img_idx, vga_we, vga_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        frame_req = 1'b1; frame_img_idx = 1'b1; pix_valid = 1'b1; pix_data = 8'($urandom);
        n = 0; t = 0;
        while (n < 100 && t < 400) begin
            @(negedge clk);
            frame_req = 1'b0;
            if (pix_ready) n++;
            pix_data = 8'($urandom | 32'h80);
            t++;
        end
        vectors++;
        if (n != 100) begin miscompares++; $display("FAIL reset_prefill: got %0d handshakes want 100", n); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({frame_busy, frame_done, pix_ready, vga_start, vga_img_idx, vga_we, vga_wdata} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: got %h want 0", {frame_busy, frame_done, pix_ready, vga_start, vga_img_idx, vga_we, vga_wdata});
        end
        rst_n = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        frame_req = 1'b1; frame_img_idx = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        vectors++;
        if ({vga_start, frame_busy, vga_img_idx, vga_we} !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_restart: got start/busy/idx/we=%b want 1110", {vga_start, frame_busy, vga_img_idx, vga_we});
        end
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
        vectors++;
        if (frame_busy !== 1'b0) begin miscompares++; $display("FAIL reset_abort_idle: got busy=%b want 0", frame_busy); end
    endtask

    task automatic test_full_frame();
        fill_random();
        run_frame(1'b1, 100, -1, 1'b0, 1'b0);
        vectors++;
        if (r_timeout != 0) begin miscompares++; $display("FAIL full_timeout: got %0d want 0", r_timeout); end
        vectors++;
        if (r_starts != 1 || r_start_cyc != r_req_cyc + 1) begin
            miscompares++; $display("FAIL full_start: got %0d pulses at %0d want 1 at %0d", r_starts, r_start_cyc, r_req_cyc + 1);
        end
        vectors++;
        if (r_writes != TOTAL || r_last_we - r_first_we + 1 != TOTAL) begin
            miscompares++; $display("FAIL full_contiguous: got %0d writes over %0d cycles want %0d", r_writes, r_last_we - r_first_we + 1, TOTAL);
        end
        vectors++;
        if (r_order_err != 0 || r_lat_err != 0 || r_left != 0) begin
            miscompares++; $display("FAIL full_data: got %0d data / %0d latency errors, %0d left want 0", r_order_err, r_lat_err, r_left);
        end
        vectors++;
        if (r_dones != 1 || r_done_cyc != r_last_hs + 3 || r_done_cyc != r_last_we + 1) begin
            miscompares++; $display("FAIL full_done: got %0d pulses at %0d want 1 at %0d", r_dones, r_done_cyc, r_last_hs + 3);
        end
        vectors++;
        if (r_idx_err != 0 || r_both != 0 || r_busy_after_done != 0) begin
            miscompares++; $display("FAIL full_ctrl: got idx_err=%0d start_we=%0d busy_after=%0d want 0", r_idx_err, r_both, r_busy_after_done);
        end
    endtask

    task automatic test_conversion();
        logic [11:0] want [8];
        int          pos  [8];
        fill_random();
        pos = '{0, 1, 2, 3, 4, 5, DIM, DIM + 1};
        img[0] = 8'h78; img[1] = 8'hF8; img[2] = 8'hA7; img[3] = 8'h78;
        img[4] = 8'hFF; img[5] = 8'h0F; img[DIM] = 8'h78; img[DIM + 1] = 8'h7C;
`ifdef VGA_FEED_DITHER_EN
        want = '{12'h777, 12'hFFF, 12'hAAA, 12'h888, 12'hFFF, 12'h111, 12'h888, 12'h888};
`else
        want = '{12'h777, 12'hFFF, 12'hAAA, 12'h777, 12'hFFF, 12'h000, 12'h777, 12'h777};
`endif
        run_frame(1'b0, 100, -1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[pos[i]] !== want[i]) begin
                miscompares++; $display("FAIL conv_pix%0d: got %h want %h", pos[i], got[pos[i]], want[i]);
            end
        end
        vectors++;
        if (r_writes != TOTAL || r_order_err != 0) begin
            miscompares++; $display("FAIL conv_frame: got %0d writes %0d errors want %0d/0", r_writes, r_order_err, TOTAL);
        end
    endtask

    task automatic test_random_gaps();
        fill_random();
        run_frame(1'b0, 50, -1, 1'b0, 1'b0);
        vectors++;
        if (r_timeout != 0 || r_writes != TOTAL) begin
            miscompares++; $display("FAIL gaps_writes: got %0d (timeout %0d) want %0d", r_writes, r_timeout, TOTAL);
        end
        vectors++;
        if (r_order_err != 0 || r_lat_err != 0 || r_left != 0) begin
            miscompares++; $display("FAIL gaps_order: got %0d data / %0d latency errors want 0", r_order_err, r_lat_err);
        end
        vectors++;
        if (r_ready_after != 0) begin miscompares++; $display("FAIL gaps_ready_after: got %0d cycles want 0", r_ready_after); end
        vectors++;
        if (r_dones != 1 || r_done_cyc != r_last_we + 1 || r_idx_err != 0) begin
            miscompares++; $display("FAIL gaps_done: got %0d at %0d idx_err %0d want 1 at %0d", r_dones, r_done_cyc, r_idx_err, r_last_we + 1);
        end
    endtask

    task automatic test_idle_abort();
        @(negedge clk);
        frame_req = 1'b1; frame_abort = 1'b1; frame_img_idx = 1'b1;
        @(negedge clk);
        frame_req = 1'b0; frame_abort = 1'b0;
        vectors++;
        if ({frame_busy, vga_start} !== 2'b00) begin
            miscompares++; $display("FAIL idle_req_abort: got busy/start=%b want 00", {frame_busy, vga_start});
        end
        @(negedge clk);
        vectors++;
        if ({frame_busy, vga_start} !== 2'b00) begin
            miscompares++; $display("FAIL idle_req_abort_late: got busy/start=%b want 00", {frame_busy, vga_start});
        end
    endtask

    task automatic test_abort();
        fill_random();
        run_frame(1'b1, 100, 1000, 1'b1, 1'b1);
        vectors++;
        if (r_writes != 1000 || r_order_err != 0) begin
            miscompares++; $display("FAIL abort_writes: got %0d writes %0d errors want 1000/0", r_writes, r_order_err);
        end
        vectors++;
        if (r_we_after_abort != 0 || r_dones != 0 || r_busy_after_abort != 0) begin
            miscompares++; $display("FAIL abort_quiet: got we=%0d done=%0d busy=%0d want 0", r_we_after_abort, r_dones, r_busy_after_abort);
        end
        vectors++;
        if (r_starts != 1 || r_idx_err != 0) begin
            miscompares++; $display("FAIL abort_busy_req: got %0d starts %0d idx errors want 1/0", r_starts, r_idx_err);
        end
    endtask

    task automatic test_after_abort();
        fill_random();
        run_frame(1'b0, 100, -1, 1'b0, 1'b0);
        vectors++;
        if (r_writes != TOTAL || r_order_err != 0 || r_lat_err != 0 || r_dones != 1) begin
            miscompares++; $display("FAIL after_abort_frame: got %0d writes %0d errors %0d done want %0d/0/1", r_writes, r_order_err + r_lat_err, r_dones, TOTAL);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_conversion();
        test_random_gaps();
        test_idle_abort();
        test_abort();
        test_after_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion within 100000 cycles");
        $fatal(1);
    end

endmodule
